// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback queue: sizing defaults, flag bit
// positions and the queue entry layout.
package alu_wb_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int DW_DEF    = 16;

  localparam int FLG_CARRY = 0;
  localparam int FLG_CMP   = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_NEG   = 3;

  typedef logic [3:0] flags_t;

  // Entry layout at the default datapath width; the top mirrors it at DW.
  typedef struct packed {
    logic [DW_DEF-1:0] result;
    flags_t            flags;
  } entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic first-word-fall-through queue: a word written at edge N is on
// rd_data in cycle N+1; full/empty come from the registered count only.
module alu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback queue: tags results with flags and buffers them FWFT
// (one-cycle latency); results offered while full are dropped and counted.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          alu_out,
  input  logic                   carry_out,
  input  logic                   compare,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_result,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
);

  typedef struct packed {
    logic [DW-1:0] result;
    flags_t        flags;
  } wb_entry_t;

  localparam int EW = $bits(wb_entry_t);

  wb_entry_t     in_entry;
  wb_entry_t     head;
  logic [EW-1:0] head_raw;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  always_comb begin
    in_entry.result           = alu_out;
    in_entry.flags            = '0;
    in_entry.flags[FLG_CARRY] = carry_out;
    in_entry.flags[FLG_CMP]   = compare;
    in_entry.flags[FLG_ZERO]  = (alu_out == '0);
    in_entry.flags[FLG_NEG]   = alu_out[DW-1];
  end

  // Readiness follows the registered occupancy, so a same-cycle pop never
  // opens the input.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (in_entry),
    .rd_en   (pop),
    .rd_data (head_raw),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign head       = wb_entry_t'(head_raw);
  assign out_result = out_valid ? head.result : '0;
  assign out_flags  = out_valid ? head.flags  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback (DEPTH=4, DW=16) with hand-computed
// expectations checked by immediate assertions.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic        carry_out;
  logic        compare;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  alu_writeback #(.DEPTH(4), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_out    (alu_out),
    .carry_out  (carry_out),
    .compare    (compare),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .count      (count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_head;

    rst = 1'b1; in_valid = 1'b0; alu_out = '0; carry_out = 1'b0;
    compare = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Push zero with carry while consumer is ready: visible only next cycle.
    in_valid = 1'b1; alu_out = 16'h0000; carry_out = 1'b1; compare = 1'b0; out_ready = 1'b1;
    #1;
    chk("latency_not_yet", out_valid, 0);
    tick();
    in_valid = 1'b0; carry_out = 1'b0;
    chk("first_out_valid", out_valid, 1);
    chk("first_out_result", out_result, 16'h0000);
    chk("first_out_flags", out_flags, 4'b0101);
    tick();
    chk("first_popped_count", count, 0);
    tick();
    chk("pop_empty_ignored", count, 0);

    // Fill with consumer stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_out = 16'h8001; compare = 1'b1; tick();
    compare = 1'b0;
    alu_out = 16'h0002; tick();
    alu_out = 16'h0003; tick();
    alu_out = 16'h0004; tick();
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    alu_out = 16'h0005; tick();
    in_valid = 1'b0;
    chk("drop_one", drop_cnt, 1);
    chk("stall_head_result", out_result, 16'h8001);
    chk("stall_head_flags", out_flags, 4'b1010);
    chk("stall_count", count, 4);

    // Full + push + pop: pop only, and the rejected push counts as a drop.
    in_valid = 1'b1; alu_out = 16'h0006; out_ready = 1'b1;
    tick();
    chk("full_pop_only_count", count, 3);
    chk("full_pop_only_head", out_result, 16'h0002);
    chk("full_pop_drop", drop_cnt, 2);

    // Streaming push/pop across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      alu_out = 16'h0100 + 16'(i);
      exp_head = (i < 3) ? 16'(16'h0002 + i) : 16'(16'h0100 + i - 3);
      chk("stream_head", out_result, exp_head);
      tick();
      chk("stream_count", count, 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_head", out_result, 16'h0107 + 16'(i));
      tick();
    end
    chk("drain_count", count, 0);
    chk("drain_out_valid", out_valid, 0);

    // Refill and hammer with rejected pushes until drop_cnt saturates.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_out = 16'h00A0 + 16'(i);
      tick();
    end
    alu_out = 16'hFFFF;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    chk("drop_saturate", drop_cnt, 255);
    chk("sat_head", out_result, 16'h00A0);
    chk("sat_count", count, 4);

    // Flush wins over a simultaneous push and pop.
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("pre_flush_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; alu_out = 16'h0777;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_result", out_result, 0);
    chk("flush_out_flags", out_flags, 0);
    chk("flush_drop_kept", drop_cnt, 255);
    chk("flush_in_ready", in_ready, 1);

    // Reset mid-stream wins over a push.
    in_valid = 1'b1; alu_out = 16'h0011; tick();
    alu_out = 16'h0022; tick();
    chk("pre_rst_count", count, 2);
    rst = 1'b1; alu_out = 16'h0033;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_result", out_result, 0);
    chk("mid_rst_out_flags", out_flags, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_drop_cnt", drop_cnt, 0);

    // Pointers restart cleanly after reset.
    in_valid = 1'b1; alu_out = 16'h1234; tick();
    in_valid = 1'b0;
    chk("post_rst_head", out_result, 16'h1234);
    chk("post_rst_flags", out_flags, 4'b0000);
    chk("post_rst_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DEPTH, default 4, result-queue entries (power of two, 2..16).
REQ-002 Parameter DW, default 16, result data width, matching the ALU datapath.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  ALU result present this cycle.
REQ-006 in_ready  output  1  queue can accept a result.
REQ-007 alu_out  input  DW  ALU result word.
REQ-008 carry_out  input  1  ALU carry flag.
REQ-009 compare  input  1  ALU compare flag.
REQ-010 flush  input  1  discard all queued entries.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 out_result  output  DW  head entry result.
REQ-014 out_flags  output  4  head flags {negative, zero, compare, carry} (bit3..bit0).
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 drop_cnt  output  8  saturating count of rejected results.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH); a pop in the same cycle SHALL NOT raise in_ready combinationally.
REQ-019 Flags computed at push: carry=carry_out, compare=compare, zero=(alu_out==0), negative=alu_out[DW-1].
REQ-020 Queue is first-word-fall-through: an entry pushed at edge N is visible on out_* in cycle N+1 (one-cycle latency).
REQ-021 out_valid SHALL equal (count != 0); out_result and out_flags SHALL be 0 when out_valid is 0.
REQ-022 Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
REQ-023 Push and pop at count==DEPTH: pop only (push rejected by REQ-018), count becomes DEPTH-1.
REQ-024 Pop at count==0 is ignored; push at count==0 with out_ready=1 still takes one cycle to appear.
REQ-025 Read/write pointers wrap modulo DEPTH without loss or duplication.
REQ-026 in_valid && !in_ready increments drop_cnt by 1, saturating at 255; rejected data is discarded.
REQ-027 flush SHALL, at the next edge, set count=0 and both pointers to 0; flush has priority over simultaneous push and pop; drop_cnt unaffected.
REQ-028 out_* SHALL remain stable while out_valid && !out_ready.

Reset
REQ-029 On rst high at an edge: count=0, pointers=0, drop_cnt=0, out_valid=0, out_result=0, out_flags=0, in_ready=1.
REQ-030 rst SHALL override flush, push and pop in the same cycle; reset mid-stream discards all entries.
REQ-031 Storage array contents need no reset; only pointers/counters define visibility.

Structure
REQ-032 Shared package alu_wb_pkg holds DEPTH default, flag bit-index constants (FLG_CARRY=0, FLG_CMP=1, FLG_ZERO=2, FLG_NEG=3) and the entry struct {result, flags}.
REQ-033 One sub-module alu_wb_fifo (generic FWFT storage, pointers, count); flag generation and drop counter live in the top.

Verification
REQ-034 Reset, then push 16'h0000 (carry=1,compare=0) -> next cycle out_valid=1, out_result=16'h0000, out_flags=4'b0101.
REQ-035 out_ready=0, push 16'h8001,16'h0002,16'h0003,16'h0004 -> count=4, in_ready=0; 5th push 16'h0005 -> drop_cnt=1, head still 16'h8001 with flags bit3=1.
REQ-036 Full queue, assert out_ready and in_valid one cycle -> pop only, count=3; continuous push/pop for 10 results -> output order equals input order across pointer wrap.
REQ-037 300 consecutive rejected pushes at full -> drop_cnt saturates at 255.
REQ-038 count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_result=0.
REQ-039 count=2, rst=1 with flush=0 and in_valid=1 -> next cycle all outputs at REQ-029 values, drop_cnt=0.
